// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end with prefetch FIFO.
// Keeps several requests in flight and flushes on redirect.
module fetch_prefetch_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH = 4,
    parameter int MAX_OUT = 2,
    parameter int PC_STEP = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              req,
    input  logic              reset,
    output logic              instr_req_out,
    output logic [ADDR_W-1:0] instr_addr_out,
    input  logic              gnt_in,
    input  logic              instr_rvalid_in,
    input  logic [DATA_W-1:0] instr_rdata_in,
    input  logic              branch_mispredicted_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              stall_in,
    output logic              instr_valid_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [6:0]        opc,
    output logic              protocol_err_out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int SW = CW + OW;
    localparam logic [TW-1:0] TLAST = TW'(MAX_OUT - 1);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic              req_kill;

    logic [ADDR_W-1:0] trk_addr [MAX_OUT];
    logic              trk_kill [MAX_OUT];
    logic [TW-1:0]     trk_wp;
    logic [TW-1:0]     trk_rp;
    logic [OW-1:0]     infl_cnt;
    logic [OW-1:0]     infl_nxt;

    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PW-1:0]     fifo_wp;
    logic [PW-1:0]     fifo_rp;
    logic [CW-1:0]     fifo_cnt;
    logic [CW-1:0]     fifo_nxt;

    logic redirect;
    logic granted;
    logic trk_pop;
    logic fifo_push;
    logic fifo_pop;
    logic credit;
    logic err;

    assign redirect  = branch_mispredicted_in;
    assign granted   = (state == REQ) && gnt_in;
    assign trk_pop   = instr_rvalid_in && (infl_cnt != '0);
    assign fifo_push = trk_pop && !trk_kill[trk_rp] && !redirect;
    assign fifo_pop  = (fifo_cnt != '0) && !stall_in && !redirect;

    // Occupancy after this edge; credit means room for one more request.
    always_comb begin
        infl_nxt = infl_cnt + OW'(granted) - OW'(trk_pop);
        fifo_nxt = fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
        if (redirect) fifo_nxt = '0;
        credit = ((SW'(fifo_nxt) + SW'(infl_nxt)) < SW'(DEPTH))
                 && (infl_nxt < OW'(MAX_OUT));
    end

    // Request FSM state register.
    always_ff @(posedge req or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Request FSM next state and bus outputs.
    always_comb begin
        state_nxt      = state;
        instr_req_out  = 1'b0;
        instr_addr_out = '0;
        unique case (state)
            IDLE: begin
                if (credit) state_nxt = REQ;
            end
            REQ: begin
                instr_req_out  = 1'b1;
                instr_addr_out = req_addr;
                if (gnt_in && !credit) state_nxt = IDLE;
            end
        endcase
    end

    // A killed request was issued for a stale PC, so it does not advance fetch_pc.
    always_comb begin
        fetch_pc_nxt = fetch_pc;
        if (redirect)
            fetch_pc_nxt = pc_in;
        else if (granted && !req_kill)
            fetch_pc_nxt = fetch_pc + ADDR_W'(PC_STEP);
    end

    // Fetch PC and the latched request address/kill flag.
    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            req_kill <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            if (state_nxt == REQ && (state == IDLE || granted)) begin
                req_addr <= fetch_pc_nxt;
                req_kill <= 1'b0;
            end else if (state == REQ && !granted && redirect) begin
                req_kill <= 1'b1;
            end
        end
    end

    // In-flight tracker pointers and count.
    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            trk_wp   <= '0;
            trk_rp   <= '0;
            infl_cnt <= '0;
        end else begin
            if (granted) trk_wp <= (trk_wp == TLAST) ? '0 : trk_wp + TW'(1);
            if (trk_pop) trk_rp <= (trk_rp == TLAST) ? '0 : trk_rp + TW'(1);
            infl_cnt <= infl_nxt;
        end
    end

    // Tracker storage; a redirect kills everything, including this edge's push.
    always_ff @(posedge req) begin
        if (redirect) begin
            for (int i = 0; i < MAX_OUT; i++) trk_kill[i] <= 1'b1;
        end
        if (granted) begin
            trk_addr[trk_wp] <= req_addr;
            trk_kill[trk_wp] <= req_kill | redirect;
        end
    end

    // Prefetch FIFO pointers and count.
    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else if (redirect) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) fifo_wp <= fifo_wp + PW'(1);
            if (fifo_pop)  fifo_rp <= fifo_rp + PW'(1);
            fifo_cnt <= fifo_nxt;
        end
    end

    // Prefetch FIFO storage.
    always_ff @(posedge req) begin
        if (fifo_push) begin
            fifo_pc[fifo_wp]   <= trk_addr[trk_rp];
            fifo_data[fifo_wp] <= instr_rdata_in;
        end
    end

    // Sticky flag for a response with nothing outstanding.
    always_ff @(posedge req or negedge reset) begin
        if (!reset)                             err <= 1'b0;
        else if (instr_rvalid_in && infl_cnt == '0) err <= 1'b1;
    end

    // Head of FIFO to decode; zero when empty.
    always_comb begin
        instr_valid_out = (fifo_cnt != '0);
        instr_out       = instr_valid_out ? fifo_data[fifo_rp] : '0;
        pc_out          = instr_valid_out ? fifo_pc[fifo_rp] : '0;
        opc             = instr_out[6:0];
        protocol_err_out = err;
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue.
// Memory model plus in-order stream model of what decode must see.
module tb_fetch_prefetch_queue;

    localparam int MAX_OUT = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req_out;
    logic [31:0] instr_addr_out;
    logic        gnt_in = 1'b0;
    logic        instr_rvalid_in = 1'b0;
    logic [31:0] instr_rdata_in = '0;
    logic        branch_mispredicted_in = 1'b0;
    logic [31:0] pc_in = '0;
    logic        stall_in = 1'b0;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [6:0]  opc;
    logic        protocol_err_out;

    always #5 clk = ~clk;

    fetch_prefetch_queue dut (
        .req(clk),
        .reset(rst_n),
        .instr_req_out(instr_req_out),
        .instr_addr_out(instr_addr_out),
        .gnt_in(gnt_in),
        .instr_rvalid_in(instr_rvalid_in),
        .instr_rdata_in(instr_rdata_in),
        .branch_mispredicted_in(branch_mispredicted_in),
        .pc_in(pc_in),
        .stall_in(stall_in),
        .instr_valid_out(instr_valid_out),
        .instr_out(instr_out),
        .pc_out(pc_out),
        .opc(opc),
        .protocol_err_out(protocol_err_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_due;
    int grants;
    int pops;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] gaddr[$];
    logic [31:0] exp_pc;
    logic [31:0] first_pop_pc;
    bit          got_pop;
    bit          prev_hold;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        gnt_in = 1'b0;
        instr_rvalid_in = 1'b0;
        instr_rdata_in = '0;
        branch_mispredicted_in = 1'b0;
        pc_in = '0;
        stall_in = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        gaddr.delete();
        exp_pc = '0;
        last_due = -1;
        grants = 0;
        pops = 0;
        got_pop = 1'b0;
        prev_hold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs from sampled outputs, check, advance to next negedge.
    task automatic step(input int gnt_pct, input int dlo, input int dhi,
                        input int stall_pct, input bit redir,
                        input logic [31:0] tgt, input bit force_rv);
        logic [31:0] w;
        int d;
        int due;
        if (prev_hold) begin
            checks++;
            if (instr_req_out !== 1'b1 || instr_addr_out !== prev_addr) begin
                errors++;
                $display("FAIL addr_hold req=%0b addr=%h required req=1 addr=%h",
                         instr_req_out, instr_addr_out, prev_addr);
            end
        end
        instr_rvalid_in = 1'b0;
        instr_rdata_in = '0;
        if (force_rv) begin
            instr_rvalid_in = 1'b1;
            instr_rdata_in = 32'hDEADBEEF;
        end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            instr_rvalid_in = 1'b1;
            instr_rdata_in = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        gnt_in = instr_req_out && (int'($urandom_range(99)) < gnt_pct);
        if (gnt_in) begin
            d = int'($urandom_range(dhi, dlo));
            due = cyc + d;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(instr_addr_out);
            pend_due.push_back(due);
            gaddr.push_back(instr_addr_out);
            grants++;
            checks++;
            if (pend_addr.size() > MAX_OUT) begin
                errors++;
                $display("FAIL outstanding got=%0d required<=%0d",
                         pend_addr.size(), MAX_OUT);
            end
        end
        stall_in = (int'($urandom_range(99)) < stall_pct);
        branch_mispredicted_in = redir;
        pc_in = redir ? tgt : $urandom;
        if (instr_valid_out && !stall_in && !redir) begin
            w = mem_word(exp_pc);
            checks++;
            if (pc_out !== exp_pc || instr_out !== w || opc !== w[6:0]) begin
                errors++;
                $display("FAIL stream pc=%h instr=%h opc=%h required pc=%h instr=%h opc=%h",
                         pc_out, instr_out, opc, exp_pc, w, w[6:0]);
            end
            if (!got_pop) begin
                got_pop = 1'b1;
                first_pop_pc = pc_out;
            end
            pops++;
            exp_pc = exp_pc + 32'd1;
        end
        if (redir) exp_pc = tgt;
        prev_hold = instr_req_out && !gnt_in;
        prev_addr = instr_addr_out;
        @(posedge clk);
        @(negedge clk);
        branch_mispredicted_in = 1'b0;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (instr_req_out !== 1'b0) begin
            errors++; $display("FAIL reset_req got=%0b required=0", instr_req_out);
        end
        checks++;
        if (instr_addr_out !== 32'h0) begin
            errors++; $display("FAIL reset_addr got=%h required=0", instr_addr_out);
        end
        checks++;
        if (instr_valid_out !== 1'b0 || instr_out !== 32'h0 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_out valid=%0b instr=%h pc=%h required all 0",
                     instr_valid_out, instr_out, pc_out);
        end
        checks++;
        if (opc !== 7'h0 || protocol_err_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_misc opc=%h err=%0b required 0", opc, protocol_err_out);
        end
    endtask

    task automatic test_stream();
        int p0;
        logic [31:0] a;
        do_reset();
        repeat (15) step(100, 1, 1, 0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a = i;
            checks++;
            if (gaddr.size() <= i || gaddr[i] !== a) begin
                errors++;
                $display("FAIL stream_addr idx=%0d got=%h required=%h",
                         i, (gaddr.size() > i) ? gaddr[i] : 32'hX, a);
            end
        end
        p0 = pops;
        repeat (10) step(100, 1, 1, 0, 1'b0, '0, 1'b0);
        checks++;
        if (pops - p0 != 10) begin
            errors++;
            $display("FAIL stream_rate got=%0d required=10", pops - p0);
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (15) step(100, 1, 1, 100, 1'b0, '0, 1'b0);
        checks++;
        if (grants != DEPTH) begin
            errors++; $display("FAIL stall_grants got=%0d required=%0d", grants, DEPTH);
        end
        checks++;
        if (instr_req_out !== 1'b0 || instr_valid_out !== 1'b1 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL stall_state req=%0b valid=%0b pc=%h required req=0 valid=1 pc=0",
                     instr_req_out, instr_valid_out, pc_out);
        end
        repeat (6) step(0, 1, 1, 0, 1'b0, '0, 1'b0);
        checks++;
        if (pops != DEPTH || instr_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain pops=%0d valid=%0b required pops=4 valid=0",
                     pops, instr_valid_out);
        end
        checks++;
        if (instr_req_out !== 1'b1 || instr_addr_out !== 32'd4) begin
            errors++;
            $display("FAIL stall_resume req=%0b addr=%h required req=1 addr=4",
                     instr_req_out, instr_addr_out);
        end
    endtask

    task automatic test_gnt_hold();
        int p0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 0, 1'b0, '0, 1'b0);
            checks++;
            if (instr_req_out !== 1'b1 || instr_addr_out !== 32'd4) begin
                errors++;
                $display("FAIL gnt_hold cyc=%0d req=%0b addr=%h required req=1 addr=4",
                         i, instr_req_out, instr_addr_out);
            end
        end
        p0 = pops;
        repeat (10) step(100, 1, 1, 0, 1'b0, '0, 1'b0);
        checks++;
        if (pops <= p0) begin
            errors++; $display("FAIL gnt_resume pops=%0d required>%0d", pops, p0);
        end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        n = 0;
        while (pend_addr.size() < 2 && n < 10) begin
            step(100, 3, 3, 0, 1'b0, '0, 1'b0);
            n++;
        end
        checks++;
        if (pend_addr.size() != 2) begin
            errors++;
            $display("FAIL redir_setup inflight=%0d required=2", pend_addr.size());
        end
        got_pop = 1'b0;
        step(100, 1, 1, 0, 1'b1, 32'h40, 1'b0);
        checks++;
        if (instr_valid_out !== 1'b0) begin
            errors++; $display("FAIL redir_flush valid=%0b required=0", instr_valid_out);
        end
        n = 0;
        while (!got_pop && n < 30) begin
            step(100, 1, 1, 0, 1'b0, '0, 1'b0);
            n++;
        end
        checks++;
        if (!got_pop || first_pop_pc !== 32'h40) begin
            errors++;
            $display("FAIL redir_first got_pop=%0b pc=%h required pc=40",
                     got_pop, first_pop_pc);
        end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        repeat (12) step(100, 1, 1, 0, 1'b0, '0, 1'b0);
        checks++;
        if (instr_valid_out !== 1'b1 || pend_addr.size() == 0 || pend_due[0] > cyc) begin
            errors++;
            $display("FAIL collide_setup valid=%0b inflight=%0d required valid=1 rvalid due",
                     instr_valid_out, pend_addr.size());
        end
        got_pop = 1'b0;
        step(100, 1, 1, 0, 1'b1, 32'h80, 1'b0);
        checks++;
        if (instr_valid_out !== 1'b0) begin
            errors++; $display("FAIL collide_flush valid=%0b required=0", instr_valid_out);
        end
        repeat (20) step(100, 1, 1, 0, 1'b0, '0, 1'b0);
        checks++;
        if (!got_pop || first_pop_pc !== 32'h80) begin
            errors++;
            $display("FAIL collide_first got_pop=%0b pc=%h required pc=80",
                     got_pop, first_pop_pc);
        end
    endtask

    task automatic test_protocol_err();
        do_reset();
        repeat (2) step(0, 1, 1, 0, 1'b0, '0, 1'b0);
        checks++;
        if (protocol_err_out !== 1'b0) begin
            errors++; $display("FAIL perr_clear got=%0b required=0", protocol_err_out);
        end
        step(0, 1, 1, 0, 1'b0, '0, 1'b1);
        checks++;
        if (protocol_err_out !== 1'b1 || instr_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL perr_set err=%0b valid=%0b required err=1 valid=0",
                     protocol_err_out, instr_valid_out);
        end
        repeat (12) step(100, 1, 2, 20, 1'b0, '0, 1'b0);
        checks++;
        if (protocol_err_out !== 1'b1) begin
            errors++; $display("FAIL perr_sticky got=%0b required=1", protocol_err_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (instr_req_out !== 1'b0 || instr_addr_out !== 32'h0 ||
            instr_valid_out !== 1'b0 || instr_out !== 32'h0 || pc_out !== 32'h0 ||
            opc !== 7'h0 || protocol_err_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset req=%0b addr=%h valid=%0b instr=%h pc=%h err=%0b required all 0",
                     instr_req_out, instr_addr_out, instr_valid_out, instr_out,
                     pc_out, protocol_err_out);
        end
    endtask

    task automatic test_random();
        bit r;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r = (int'($urandom_range(99)) < 4);
            step(60, 1, 4, 30, r, $urandom, 1'b0);
        end
        checks++;
        if (protocol_err_out !== 1'b0) begin
            errors++; $display("FAIL random_err got=%0b required=0", protocol_err_out);
        end
        checks++;
        if (pops < 100) begin
            errors++; $display("FAIL random_progress pops=%0d required>=100", pops);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_gnt_hold();
        test_redirect();
        test_redirect_collide();
        test_protocol_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
